// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: machine width, instruction size and the
// fetch controller state enumeration.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals, plus
// a debug view of the fetch controller state.
interface instr_fetch_if;
    import riscv_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1 (imem_req/imem_ready, instr_valid/instr_ready). While valid is high
    // and ready low, the sender holds valid and its payload unchanged. imem_rvalid
    // and redirect_valid are single-cycle pulses with no back-pressure.
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    fetch_state_e    fetch_state;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        output fetch_state
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        input  fetch_state
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, instr} entries between memory and decode.
// Flush empties it in one cycle and takes priority over read and write.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign rd_ok = rd_en_i & ~empty_o;
    // A write into a full queue is allowed only when the head leaves in the same cycle.
    assign wr_ok = wr_en_i & (~full_o | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Credit-based instruction fetch unit: issues sequential word fetches, queues
// in-order responses with their PCs and discards wrong-path responses on redirect.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic          clock,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int              CW           = $clog2(QDEPTH) + 1;
    localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(QDEPTH);
    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(INSTR_BYTES);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic              req;
    logic              accept;
    logic              rsp_ok;
    logic              consume;
    logic [CW:0]       inflight;
    logic [CW-1:0]     out_excl;
    logic [XLEN-1:0]   rsp_pc;

    logic              q_flush;
    logic              q_wr;
    logic              q_rd;
    logic [2*XLEN-1:0] q_wdata;
    logic [2*XLEN-1:0] q_rdata;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;

    // Every accepted request owns a queue slot until its instruction is consumed,
    // so a response can always be written.
    assign inflight = {1'b0, outstanding_q} + {1'b0, q_count};
    assign req      = ~reset & (state_q == FETCH) & ~bus.redirect_valid
                    & (inflight < CREDIT_LIMIT);
    assign accept   = req & bus.imem_ready;
    assign rsp_ok   = bus.imem_rvalid & (outstanding_q != '0);
    assign consume  = ~q_empty & bus.instr_ready;
    assign out_excl = outstanding_q - CW'(rsp_ok);

    // In FETCH the outstanding requests are consecutive words ending just below
    // pc_q, so the oldest one (the one responding) sits outstanding_q words back.
    assign rsp_pc  = pc_q - XLEN'({outstanding_q, 2'b00});
    assign q_wdata = {rsp_pc, bus.imem_rdata};

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = ~q_empty;
    assign bus.instr       = q_empty ? '0 : q_rdata[XLEN-1:0];
    assign bus.instr_pc    = q_empty ? '0 : q_rdata[2*XLEN-1:XLEN];
    assign bus.fetch_state = state_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q;
        q_flush       = bus.redirect_valid;
        q_rd          = consume & ~bus.redirect_valid;
        q_wr          = 1'b0;

        unique case ({accept, rsp_ok})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        unique case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    if (out_excl != '0) begin
                        state_d   = DRAIN;
                        discard_d = out_excl;
                    end
                end else begin
                    q_wr = rsp_ok & (~q_full | q_rd);
                end
            end
            DRAIN: begin
                if (rsp_ok) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase

        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc & ~XLEN'(3);
        end else if (accept) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .clk_i     (clock),
        .rst_i     (reset),
        .flush_i   (q_flush),
        .wr_en_i   (q_wr),
        .wr_data_i (q_wdata),
        .rd_en_i   (q_rd),
        .rd_data_o (q_rdata),
        .full_o    (q_full),
        .empty_o   (q_empty),
        .count_o   (q_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model, expected program-order stream,
// directed scenarios followed by randomized traffic with redirects and a mid-run reset.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem_q[$];
    int          drain_left;
    logic [31:0] exp_fetch_pc;
    logic [31:0] exp_pc;

    bit          ready_rand, ready_val;
    bit          rsp_hold, rsp_rand;
    bit          dn_rand, dn_val;
    bit          redir_rand, redir_req;
    logic [31:0] redir_target;

    logic        s_req, s_valid, s_rvalid;
    logic [31:0] s_addr, s_pc;
    bit          prev_stall, prev_hold;
    logic [31:0] prev_addr, prev_instr, prev_pc;
    int          acc_cnt, cons_cnt, cons_total;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset              = 1'b1;
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        mem_q.delete();
        drain_left   = 0;
        exp_fetch_pc = RESET_PC;
        exp_pc       = RESET_PC;
        prev_stall   = 1'b0;
        prev_hold    = 1'b0;
        acc_cnt      = 0;
        cons_cnt     = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc",    bus.instr_pc, 32'd0);
        chk("rst_state", 32'(bus.fetch_state), 32'(FETCH));
    endtask

    task automatic cycle();
        bit          rdy, rv, dn, rd;
        logic [31:0] tgt;
        @(negedge clock);
        reset = 1'b0;
        rdy = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
        rv  = (mem_q.size() > 0) && !rsp_hold && (!rsp_rand || $urandom_range(0, 2) != 0);
        dn  = dn_rand ? ($urandom_range(0, 1) == 1) : dn_val;
        rd  = redir_req || (redir_rand && $urandom_range(0, 39) == 0);
        if (redir_req) tgt = redir_target;
        else if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else tgt = $urandom;
        redir_req = 1'b0;
        bus.imem_ready     = rdy;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? mem_word(mem_q[0]) : $urandom;
        bus.instr_ready    = dn;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rd ? tgt : $urandom;
        #1;
        s_req    = bus.imem_req;
        s_addr   = bus.imem_addr;
        s_valid  = bus.instr_valid;
        s_pc     = bus.instr_pc;
        s_rvalid = rv;

        if (s_req) chk("imem_addr", s_addr, exp_fetch_pc);
        if (rd || drain_left > 0) chk("no_req", 32'(s_req), 32'd0);
        if (prev_stall && !rd) begin
            chk("stall_req", 32'(s_req), 32'd1);
            chk("stall_addr", s_addr, prev_addr);
        end
        chk("state", 32'(bus.fetch_state), (drain_left > 0) ? 32'(DRAIN) : 32'(FETCH));
        if (prev_hold) begin
            chk("hold_valid", 32'(s_valid), 32'd1);
            chk("hold_instr", bus.instr, prev_instr);
            chk("hold_pc", s_pc, prev_pc);
        end
        if (s_valid && !rd) begin
            chk("instr_pc", s_pc, exp_pc);
            chk("instr", bus.instr, mem_word(exp_pc));
            if (dn) begin
                exp_pc = exp_pc + 32'd4;
                cons_cnt++;
                cons_total++;
            end
        end

        if (rd) drain_left = mem_q.size() - (rv ? 1 : 0);
        else if (rv && drain_left > 0) drain_left--;
        if (rv) void'(mem_q.pop_front());
        if (s_req && rdy) begin
            mem_q.push_back(s_addr);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            acc_cnt++;
        end
        if (rd) begin
            exp_fetch_pc = tgt & ~32'd3;
            exp_pc       = tgt & ~32'd3;
        end
        prev_stall = s_req && !rdy && !rd;
        prev_addr  = s_addr;
        prev_hold  = s_valid && !dn && !rd;
        prev_instr = bus.instr;
        prev_pc    = s_pc;
    endtask

    task automatic set_ideal();
        ready_rand = 1'b0; ready_val = 1'b1;
        rsp_hold   = 1'b0; rsp_rand  = 1'b0;
        dn_rand    = 1'b0; dn_val    = 1'b1;
        redir_rand = 1'b0; redir_req = 1'b0;
    endtask

    initial begin
        cons_total = 0;
        set_ideal();

        // Straight-line fetch with an ideal memory and consumer
        do_reset();
        cycle();
        chk("c1_req", 32'(s_req), 32'd1);
        chk("c1_addr", s_addr, RESET_PC);
        chk("c1_valid", 32'(s_valid), 32'd0);
        cycle();
        chk("c2_addr", s_addr, 32'h4);
        chk("c2_valid", 32'(s_valid), 32'd0);
        cycle();
        chk("c3_valid", 32'(s_valid), 32'd1);
        chk("c3_pc", s_pc, 32'h0);
        repeat (12) cycle();

        // Consumer stalled: credit limits requests to the queue depth
        do_reset();
        dn_val = 1'b0;
        repeat (10) cycle();
        chk("stall_acc", 32'(acc_cnt), 32'(QDEPTH));
        chk("stall_noreq", 32'(s_req), 32'd0);
        chk("stall_head", s_pc, 32'h0);
        dn_val = 1'b1;
        cycle();
        chk("rel_pc0", s_pc, 32'h0);
        chk("rel_noreq", 32'(s_req), 32'd0);
        cycle();
        chk("rel_pc4", s_pc, 32'h4);
        chk("rel_req", 32'(s_req), 32'd1);
        chk("rel_addr", s_addr, 32'h8);
        repeat (6) cycle();

        // Redirect with two responses outstanding
        do_reset();
        rsp_hold = 1'b1;
        repeat (3) cycle();
        chk("dr_acc", 32'(acc_cnt), 32'd2);
        redir_req = 1'b1; redir_target = 32'h0000_0103;
        cycle();
        rsp_hold = 1'b0;
        cycle();
        chk("dr_req1", 32'(s_req), 32'd0);
        chk("dr_valid1", 32'(s_valid), 32'd0);
        cycle();
        chk("dr_req2", 32'(s_req), 32'd0);
        cycle();
        chk("dr_req3", 32'(s_req), 32'd1);
        chk("dr_addr3", s_addr, 32'h0000_0100);
        cycle();
        cycle();
        chk("dr_valid", 32'(s_valid), 32'd1);
        chk("dr_pc", s_pc, 32'h0000_0100);
        repeat (6) cycle();

        // Memory back-pressure holds the request
        do_reset();
        repeat (2) cycle();
        ready_val = 1'b0;
        repeat (2) cycle();
        repeat (3) begin
            cycle();
            chk("bp_req", 32'(s_req), 32'd1);
            chk("bp_addr", s_addr, 32'h8);
        end
        chk("bp_acc", 32'(acc_cnt), 32'd2);
        ready_val = 1'b1;
        cycle();
        chk("bp_acc2", 32'(acc_cnt), 32'd3);
        repeat (6) cycle();

        // PC wrap at the top of the address space
        do_reset();
        ready_val = 1'b0;
        cycle();
        redir_req = 1'b1; redir_target = 32'hFFFF_FFFC;
        cycle();
        ready_val = 1'b1;
        cycle();
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_req", 32'(s_req), 32'd1);
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        repeat (6) cycle();

        // Redirect coinciding with a response and a head consume
        do_reset();
        repeat (2) cycle();
        redir_req = 1'b1; redir_target = 32'h0000_0200;
        cycle();
        chk("co_valid", 32'(s_valid), 32'd1);
        chk("co_rvalid", 32'(s_rvalid), 32'd1);
        cycle();
        chk("co_empty", 32'(s_valid), 32'd0);
        chk("co_addr", s_addr, 32'h0000_0200);
        cycle();
        cycle();
        chk("co_pc", s_pc, 32'h0000_0200);
        repeat (6) cycle();

        // Randomized traffic with a reset in the middle
        do_reset();
        ready_rand = 1'b1; rsp_rand = 1'b1; dn_rand = 1'b1; redir_rand = 1'b1;
        repeat (1500) cycle();
        do_reset();
        repeat (1500) cycle();
        chk("progress", 32'(cons_total > 200), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
